// File: rtl/jtmx5k_sdram_sched.sv
// Four-slot ROM read scheduler in front of a single SDRAM read port.
// Each slot keeps a one-word tag/data cache; misses are served one at a time.
module jtmx5k_sdram_sched #(
    parameter int AW    = 22,
    parameter int DW    = 16,
    parameter bit PRIO0 = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            downloading,
    input  logic [3:0]      slot_cs,
    input  logic [4*AW-1:0] slot_addr,
    output logic [3:0]      slot_ok,
    output logic [4*DW-1:0] slot_dout,
    output logic            sdram_req,
    output logic [AW-1:0]   sdram_addr,
    input  logic            sdram_ack,
    input  logic            data_rdy,
    input  logic [DW-1:0]   data_read
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t          state, state_nx;
    logic [1:0]      gnt, gnt_nx;
    logic [1:0]      rr, rr_nx;
    logic            req_nx;
    logic [AW-1:0]   addr_nx;
    logic            fill;
    logic [AW-1:0]   tag  [4];
    logic [DW-1:0]   data [4];
    logic [3:0]      valid, hit, miss;
    logic            pick_ok;
    logic [1:0]      pick, idx;

    // The slot currently being fetched is not a miss, so it cannot be re-granted mid-transfer.
    for (genvar i = 0; i < 4; i++) begin : g_slot
        assign hit[i]  = valid[i] && (tag[i] == slot_addr[i*AW +: AW]);
        assign miss[i] = slot_cs[i] && !hit[i] && !(state != IDLE && gnt == 2'(i));
        assign slot_ok[i] = slot_cs[i] && hit[i];
        assign slot_dout[i*DW +: DW] = data[i];
    end

    function automatic logic [1:0] rr_after(input logic [1:0] k);
        if (PRIO0) return (k == 2'd3) ? 2'd1 : k + 2'd1;
        return k + 2'd1;
    endfunction

    always_comb begin
        pick_ok = 1'b0;
        pick    = 2'd0;
        idx     = 2'd0;
        if (PRIO0 && miss[0]) begin
            pick_ok = 1'b1;
        end else begin
            for (int k = 0; k < 4; k++) begin
                idx = rr + 2'(k);
                if (!pick_ok && miss[idx] && !(PRIO0 && idx == 2'd0)) begin
                    pick_ok = 1'b1;
                    pick    = idx;
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        rr_nx    = rr;
        req_nx   = sdram_req;
        addr_nx  = sdram_addr;
        fill     = 1'b0;
        case (state)
            IDLE: begin
                if (!downloading && pick_ok) begin
                    gnt_nx   = pick;
                    addr_nx  = slot_addr[pick*AW +: AW];
                    req_nx   = 1'b1;
                    state_nx = REQ;
                    if (!(PRIO0 && pick == 2'd0)) rr_nx = rr_after(pick);
                end
            end
            REQ: begin
                if (downloading) begin
                    req_nx   = 1'b0;
                    state_nx = IDLE;
                end else if (sdram_ack) begin
                    req_nx   = 1'b0;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                // Data arriving during a download is consumed but never cached.
                if (data_rdy) begin
                    fill     = !downloading;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= 2'd0;
            rr         <= 2'd1;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
        end else begin
            state      <= state_nx;
            gnt        <= gnt_nx;
            rr         <= rr_nx;
            sdram_req  <= req_nx;
            sdram_addr <= addr_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < 4; i++) begin
                tag[i]  <= '0;
                data[i] <= '0;
            end
        end else if (downloading) begin
            valid <= '0;
        end else if (fill) begin
            valid[gnt] <= 1'b1;
            tag[gnt]   <= sdram_addr;
            data[gnt]  <= data_read;
        end
    end
endmodule

// File: tb/tb_jtmx5k_sdram_sched.sv
// Directed bench for jtmx5k_sdram_sched: a cycle table for miss/hit, then
// hand-written sequences for fairness, address change, download and reset.
module tb_jtmx5k_sdram_sched;
    localparam int AW = 22;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst, downloading, ack, rdy;
    logic [3:0]      cs;
    logic [AW-1:0]   a [4];
    logic [DW-1:0]   dr;
    logic [4*AW-1:0] slot_addr;
    logic [3:0]      ok;
    logic [4*DW-1:0] dout;
    logic            req;
    logic [AW-1:0]   sdram_addr;
    int              n_chk = 0;
    int              n_fail = 0;

    always #5 clk = ~clk;
    assign slot_addr = {a[3], a[2], a[1], a[0]};

    jtmx5k_sdram_sched dut (
        .clk(clk), .rst(rst), .downloading(downloading),
        .slot_cs(cs), .slot_addr(slot_addr), .slot_ok(ok), .slot_dout(dout),
        .sdram_req(req), .sdram_addr(sdram_addr), .sdram_ack(ack),
        .data_rdy(rdy), .data_read(dr)
    );

    typedef struct packed {
        logic [3:0]    cs;
        logic [AW-1:0] addr0;
        logic          ack;
        logic          rdy;
        logic [DW-1:0] dr;
        logic [AW-1:0] exp_addr;
        logic          exp_req;
        logic [3:0]    exp_ok;
        logic [DW-1:0] exp_dout0;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int i);
        cs   = tbl[i].cs;
        a[0] = tbl[i].addr0;
        ack  = tbl[i].ack;
        rdy  = tbl[i].rdy;
        dr   = tbl[i].dr;
        #1;
        chk($sformatf("tbl%0d_req", i), 32'(req), 32'(tbl[i].exp_req));
        chk($sformatf("tbl%0d_addr", i), 32'(sdram_addr), 32'(tbl[i].exp_addr));
        chk($sformatf("tbl%0d_ok", i), 32'(ok), 32'(tbl[i].exp_ok));
        chk($sformatf("tbl%0d_dout0", i), 32'(dout[DW-1:0]), 32'(tbl[i].exp_dout0));
        @(negedge clk);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!req && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_req"}, 32'(req), 32'd1);
    endtask

    task automatic grant(input int k, input string name);
        wait_req(name);
        chk({name, "_addr"}, 32'(sdram_addr), 32'(a[k]));
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk({name, "_reqdrop"}, 32'(req), 32'd0);
    endtask

    task automatic fill(input int k, input logic [DW-1:0] d, input logic exp_ok, input string name);
        repeat (2) @(negedge clk);
        rdy = 1'b1;
        dr  = d;
        @(negedge clk);
        rdy = 1'b0;
        chk({name, "_ok"}, 32'(ok[k]), 32'(exp_ok));
        if (exp_ok) chk({name, "_dout"}, 32'(dout[k*DW +: DW]), 32'(d));
    endtask

    initial begin
        rst = 1'b1; downloading = 1'b0; ack = 1'b0; rdy = 1'b0; dr = '0; cs = '0;
        for (int i = 0; i < 4; i++) a[i] = '0;

        //          cs     addr0        ack  rdy  dr        exp_addr     req  ok     dout0
        tbl[0]  = '{4'h0, 22'h001234, 1'b0, 1'b0, 16'h0000, 22'h000000, 1'b0, 4'h0, 16'h0000};
        tbl[1]  = '{4'h1, 22'h001234, 1'b0, 1'b0, 16'h0000, 22'h000000, 1'b0, 4'h0, 16'h0000};
        tbl[2]  = '{4'h1, 22'h001234, 1'b0, 1'b0, 16'h0000, 22'h001234, 1'b1, 4'h0, 16'h0000};
        tbl[3]  = '{4'h1, 22'h001234, 1'b0, 1'b0, 16'h0000, 22'h001234, 1'b1, 4'h0, 16'h0000};
        tbl[4]  = '{4'h1, 22'h001234, 1'b1, 1'b0, 16'h0000, 22'h001234, 1'b1, 4'h0, 16'h0000};
        tbl[5]  = '{4'h1, 22'h001234, 1'b0, 1'b0, 16'h0000, 22'h001234, 1'b0, 4'h0, 16'h0000};
        tbl[6]  = '{4'h1, 22'h001234, 1'b0, 1'b0, 16'h0000, 22'h001234, 1'b0, 4'h0, 16'h0000};
        tbl[7]  = '{4'h1, 22'h001234, 1'b0, 1'b0, 16'h0000, 22'h001234, 1'b0, 4'h0, 16'h0000};
        tbl[8]  = '{4'h1, 22'h001234, 1'b0, 1'b0, 16'h0000, 22'h001234, 1'b0, 4'h0, 16'h0000};
        tbl[9]  = '{4'h1, 22'h001234, 1'b0, 1'b1, 16'hBEEF, 22'h001234, 1'b0, 4'h0, 16'h0000};
        tbl[10] = '{4'h1, 22'h001234, 1'b0, 1'b0, 16'h0000, 22'h001234, 1'b0, 4'h1, 16'hBEEF};
        tbl[11] = '{4'h0, 22'h001234, 1'b0, 1'b0, 16'h0000, 22'h001234, 1'b0, 4'h0, 16'hBEEF};
        tbl[12] = '{4'h1, 22'h001234, 1'b0, 1'b0, 16'h0000, 22'h001234, 1'b0, 4'h1, 16'hBEEF};
        tbl[13] = '{4'h1, 22'h001234, 1'b0, 1'b0, 16'h0000, 22'h001234, 1'b0, 4'h1, 16'hBEEF};

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // T1/T2: single miss, then hit after cs toggles
        for (int i = 0; i < 14; i++) step(i);

        // T3: slots 1..3 always missing, slot 0 joins late and wins
        a[1] = 22'h000100; a[2] = 22'h000200; a[3] = 22'h000300;
        cs = 4'b1110;
        for (int r = 0; r < 6; r++) begin
            int k;
            k = 1 + (r % 3);
            grant(k, $sformatf("t3_g%0d", r));
            if (r == 5) begin
                a[0] = 22'h000400;
                cs[0] = 1'b1;
            end
            fill(k, 16'hA000 + 16'(r), 1'b1, $sformatf("t3_f%0d", r));
            a[k] = a[k] + 22'h10;
        end
        grant(0, "t3_g0");
        fill(0, 16'hA100, 1'b1, "t3_f0");
        grant(1, "t3_g1after0");
        fill(1, 16'hA101, 1'b1, "t3_f1after0");
        cs = 4'b0000;

        // T4: address changes while the fill is outstanding
        a[2] = 22'h000010;
        cs = 4'b0100;
        grant(2, "t4_g10");
        a[2] = 22'h000020;
        fill(2, 16'h1111, 1'b0, "t4_stale");
        grant(2, "t4_g20");
        fill(2, 16'h2222, 1'b1, "t4_f20");

        // T5: download starts while waiting for data
        a[2] = 22'h000030;
        cs = 4'b0110;
        #1;
        chk("t5_hit1", 32'(ok[1]), 32'd1);
        grant(2, "t5_g30");
        downloading = 1'b1;
        @(negedge clk);
        chk("t5_flush", 32'(ok), 32'd0);
        fill(2, 16'h3333, 1'b0, "t5_discard");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("t5_noreq%0d", i), {31'd0, req}, 32'd0);
            chk($sformatf("t5_nook%0d", i), 32'(ok), 32'd0);
        end
        downloading = 1'b0;
        grant(1, "t5_re1");
        fill(1, 16'h4444, 1'b1, "t5_rf1");
        grant(2, "t5_re2");
        fill(2, 16'h5555, 1'b1, "t5_rf2");

        // T6: reset while a request is pending
        a[2] = 22'h000040;
        wait_req("t6");
        rst = 1'b1;
        cs = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_req", 32'(req), 32'd0);
        chk("t6_addr", 32'(sdram_addr), 32'd0);
        chk("t6_ok", 32'(ok), 32'd0);
        chk("t6_dout1", 32'(dout[DW +: DW]), 32'd0);
        rdy = 1'b1;
        dr = 16'h6666;
        @(negedge clk);
        rdy = 1'b0;
        chk("t6_stray_req", 32'(req), 32'd0);
        cs = 4'b0100;
        #1;
        chk("t6_stray_ok", 32'(ok), 32'd0);
        chk("t6_stray_dout2", 32'(dout[2*DW +: DW]), 32'd0);
        @(negedge clk);
        chk("t6_refetch_req", 32'(req), 32'd1);
        chk("t6_refetch_addr", 32'(sdram_addr), 32'h40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
